// File: rtl/timer_counter_dev_pkg.sv
// Shared definitions for the bus-mapped countdown timer: register offsets,
// CTRL field layout, mode codes and FSM state encodings.
package timer_counter_dev_pkg;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;
    localparam logic [1:0] ADDR_RSVD   = 2'd3;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_IM_BIT   = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'd0;
    localparam logic [1:0] MODE_RELOAD  = 2'd1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } tmr_state_e;

    // Field order matches the CTRL bit positions above (IM at bit 3, EN at bit 0).
    typedef struct packed {
        logic       im;
        logic [1:0] mode;
        logic       en;
    } ctrl_t;

    function automatic logic [31:0] ctrl_to_word(input ctrl_t c);
        return {28'd0, c};
    endfunction

endpackage

// File: rtl/timer_counter_dev.sv
// Programmable countdown timer with one-shot and auto-reload modes; IRQ is a
// level output gated by the CTRL interrupt mask.
module timer_counter_dev
    import timer_counter_dev_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    ctrl_t             ctrl_q, ctrl_d;
    logic [CNT_W-1:0]  preset_q, preset_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              irq_flag_q, irq_flag_d;
    tmr_state_e        state_q, state_d;

    logic ctrl_wr;
    logic preset_wr;
    logic en_live;

    assign ctrl_wr   = WE && (Addr == ADDR_CTRL);
    assign preset_wr = WE && (Addr == ADDR_PRESET);
    // A CTRL write landing this cycle overrides EN immediately so a stop never
    // costs one extra decrement.
    assign en_live   = ctrl_wr ? Din[CTRL_EN_BIT] : ctrl_q.en;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        irq_flag_d = irq_flag_q;
        ctrl_d     = ctrl_q;
        preset_d   = preset_q;

        case (state_q)
            ST_IDLE: begin
                if (ctrl_q.en) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (!en_live) begin
                    state_d = ST_IDLE;
                end else begin
                    count_d = preset_q;
                    state_d = ST_CNT;
                end
            end
            ST_CNT: begin
                if (!en_live) begin
                    state_d = ST_IDLE;
                end else if (count_q <= CNT_W'(1)) begin
                    count_d    = '0;
                    irq_flag_d = 1'b1;
                    state_d    = ST_INT;
                end else begin
                    count_d = count_q - CNT_W'(1);
                end
            end
            ST_INT: begin
                if (ctrl_q.mode == MODE_RELOAD) begin
                    irq_flag_d = 1'b0;
                    state_d    = ST_LOAD;
                end else begin
                    ctrl_d.en = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // CPU writes take priority over the hardware EN clear and flag set.
        if (ctrl_wr) begin
            ctrl_d     = ctrl_t'(Din[CTRL_IM_BIT:CTRL_EN_BIT]);
            irq_flag_d = 1'b0;
        end
        if (preset_wr) begin
            preset_d = CNT_W'(Din);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q     <= '0;
            preset_q   <= '0;
            count_q    <= '0;
            irq_flag_q <= 1'b0;
            state_q    <= ST_IDLE;
        end else begin
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_flag_q <= irq_flag_d;
            state_q    <= state_d;
        end
    end

    always_comb begin
        case (Addr)
            ADDR_CTRL:   Dout = ctrl_to_word(ctrl_q);
            ADDR_PRESET: Dout = 32'(preset_q);
            ADDR_COUNT:  Dout = 32'(count_q);
            default:     Dout = 32'd0;
        endcase
    end

    assign IRQ = ctrl_q.im & irq_flag_q;

endmodule
